word_serializer: RTL and testbench

//  Parallel-to-serial converter that feeds the serial bit input (din) of the downstream

---
 rtl/word_serializer_pkg.sv | 29 ++
 rtl/word_serializer.sv | 173 +++++++++++++++++
 tb/tb_word_serializer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
//   Shared definitions for the word serializer and the benches around it.
//   - ser_state_t : serializer FSM state encoding
//   - cnt_w()     : width of the per-word bit counter for a given word width
//   - DET_PATTERN : bit pattern the downstream Mealy detector looks for.
//                   The integration bench uses this constant.
// ----------------------------------------------------------------------------
package ser_pkg;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Serial pattern recognised by the downstream detector, oldest bit first
  localparam logic [3:0] DET_PATTERN = 4'b1010;

  // Counter width that can hold 0..width-1.
  // The result is clamped so that a degenerate width still yields one bit.
  function automatic int cnt_w(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/word_serializer.sv
// ----------------------------------------------------------------------------
// word_serializer
//   Parallel-to-serial converter that feeds the serial input of the
//   downstream pattern detector. WIDTH-bit words are accepted over a
//   valid/ready handshake. Each word is emitted one bit per bit_en strobe,
//   MSB or LSB first. A new word can be loaded on the strobe that consumes
//   the last bit of the current word, which gives a zero-gap stream.
//   flush aborts the current word synchronously.
//
// Parameters
//   WIDTH      bits per input word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   IDLE_BIT   level driven on dout while no word is being sent
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_data     in   parallel word, sampled on in_valid && in_ready
//   in_valid    in   in_data is valid
//   in_ready    out  word is accepted this cycle (combinational)
//   bit_en      in   bit-rate strobe; the serial stream advances only when 1
//   flush       in   synchronous abort of the current word
//   dout        out  serial bit (from registered state only)
//   dout_valid  out  dout carries a payload bit
//   busy        out  a word is being shifted out
// ----------------------------------------------------------------------------
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  input  logic             flush,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  ser_state_t       state_r;
  ser_state_t       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] shreg_r;

  logic             shifting_s;   // in SHIFT and the strobe is active
  logic             last_bit_s;   // strobe consumes the final bit of the word
  logic             load_s;       // handshake completes at the next edge

  // Strobe qualification and handshake decode
  always_comb begin
    shifting_s = (state_r == SER_SHIFT) && bit_en;
    last_bit_s = shifting_s && (cnt_r == LAST_CNT);

    // Flush masks ready so an abort never swallows a word.
    if (flush) begin
      in_ready = 1'b0;
    end else if (state_r == SER_IDLE) begin
      in_ready = 1'b1;
    end else begin
      in_ready = last_bit_s;
    end

    load_s = in_valid && in_ready;
  end

  // Next-state logic; flush has priority over any load
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = SER_IDLE;
    end else begin
      case (state_r)
        SER_IDLE: begin
          if (in_valid) begin
            next_state_s = SER_SHIFT;
          end else begin
            next_state_s = SER_IDLE;
          end
        end
        SER_SHIFT: begin
          if (last_bit_s) begin
            // Reload here keeps the stream contiguous across words
            if (in_valid) begin
              next_state_s = SER_SHIFT;
            end else begin
              next_state_s = SER_IDLE;
            end
          end else begin
            next_state_s = SER_SHIFT;
          end
        end
        default: begin
          next_state_s = SER_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SER_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bit counter: position of the bit currently on dout within the word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (flush) begin
      cnt_r <= CNT_ZERO;
    end else if (load_s) begin
      cnt_r <= CNT_ZERO;
    end else if (last_bit_s) begin
      // Word finished without a reload; park at zero for the next word
      cnt_r <= CNT_ZERO;
    end else if (shifting_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Shift register: the head bit is always the one on dout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (flush) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (load_s) begin
      shreg_r <= in_data;
    end else if (shifting_s) begin
      if (MSB_FIRST) begin
        shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
      end else begin
        shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
      end
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Serial outputs decoded only from registers, so no input reaches dout
  always_comb begin
    if (state_r == SER_SHIFT) begin
      if (MSB_FIRST) begin
        dout = shreg_r[WIDTH-1];
      end else begin
        dout = shreg_r[0];
      end
      dout_valid = 1'b1;
      busy       = 1'b1;
    end else begin
      dout       = IDLE_BIT;
      dout_valid = 1'b0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// ----------------------------------------------------------------------------
// tb_word_serializer
//   Scoreboard bench for word_serializer. The driver pushes the expected
//   serial bits when a word is handed over. A negedge monitor pops and
//   compares them whenever dout_valid is high. A second instance checks the
//   LSB-first bit order.
// ----------------------------------------------------------------------------
module tb_word_serializer;
  import ser_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       bit_en;
  logic       flush;
  logic       dout;
  logic       dout_valid;
  logic       busy;

  logic [7:0] lsb_data;
  logic       lsb_valid;
  logic       lsb_ready;
  logic       lsb_flush;
  logic       lsb_dout;
  logic       lsb_dout_valid;
  logic       lsb_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  bit mon_en  = 1'b0;
  bit exp_q[$];
  int run_len = 0;
  int last_run = 0;
  int rdy_busy_cnt = 0;
  logic [3:0] det_hist = 4'b0000;
  int det_bits = 0;
  int det_pulses = 0;
  int det_last = 0;
  int en_period = 1;
  int en_phase = 0;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_en(bit_en), .flush(flush), .dout(dout),
    .dout_valid(dout_valid), .busy(busy)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(lsb_data), .in_valid(lsb_valid),
    .in_ready(lsb_ready), .bit_en(bit_en), .flush(lsb_flush), .dout(lsb_dout),
    .dout_valid(lsb_dout_valid), .busy(lsb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit_en strobe generator: every cycle, or once every en_period cycles
  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (en_period <= 1) begin
        bit_en = 1'b1;
      end else begin
        en_phase = (en_phase + 1) % en_period;
        bit_en = (en_phase == 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop, idle level, run length, detector reference model
  always @(negedge clk) begin
    if (!rst_n) begin
      det_hist   = 4'b0000;
      det_bits   = 0;
      det_pulses = 0;
      det_last   = 0;
      run_len    = 0;
    end
    if (mon_en) begin
      n_cmp++;
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: dout_valid=1 dout=%0b, expected no payload", dout);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_fail++;
            $display("FAIL sb_bit: dout=%0b, expected %0b", dout, e);
          end
        end
        run_len++;
        det_hist = {det_hist[2:0], dout};
        det_bits++;
        if (det_bits >= 4 && det_hist == DET_PATTERN) begin
          det_pulses++;
          det_last = det_bits;
        end
      end else begin
        if (dout !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_dout: dout=%0b, expected 0", dout);
        end
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (busy && in_ready) rdy_busy_cnt++;
    end
  end

  // Offer a word; rep = cycles each bit is held; align = load on a strobe edge
  task automatic send_word(input logic [7:0] w, input int rep, input bit align);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!align || bit_en) begin
        in_data  = w;
        in_valid = 1'b1;
        #1;
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: word %0h never accepted, expected handshake", w);
      in_valid = 1'b0;
    end else begin
      for (int b = 7; b >= 0; b--) begin
        for (int r = 0; r < rep; r++) exp_q.push_back(w[b]);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dout_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bits left, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] lw;
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0;
    lsb_data = 8'h00; lsb_valid = 1'b0; lsb_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lsb_valid", {31'd0, lsb_dout_valid}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd1);

    // Single word, MSB first
    send_word(8'hA5, 1, 1'b0);
    drain();
    check("t1_run_len", last_run, 32'd8);

    // Back-to-back, zero gap
    rdy_busy_cnt = 0;
    send_word(8'h0A, 1, 1'b0);
    send_word(8'hA0, 1, 1'b0);
    drain();
    check("t2_run_len", last_run, 32'd16);
    check("t2_ready_in_shift", rdy_busy_cnt, 32'd2);

    // Strobe every 3rd cycle: each bit held three cycles
    en_period = 3;
    en_phase = 0;
    send_word(8'hC3, 3, 1'b1);
    drain();
    check("t3_run_len", last_run, 32'd24);
    en_period = 1;
    repeat (2) @(negedge clk);

    // LSB-first instance
    lw = 8'h01;
    @(negedge clk);
    lsb_data = lw; lsb_valid = 1'b1;
    #1;
    check("t4_lsb_ready", {31'd0, lsb_ready}, 32'd1);
    @(posedge clk);
    #1;
    lsb_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_lsb_valid", {31'd0, lsb_dout_valid}, 32'd1);
      check("t4_lsb_bit", {31'd0, lsb_dout}, {31'd0, lw[i]});
    end
    @(negedge clk);
    check("t4_lsb_end_valid", {31'd0, lsb_dout_valid}, 32'd0);

    // Flush after three bits with a competing word on offer
    send_word(8'hFF, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    #1;
    check("t5_ready_flush", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_dout_valid", {31'd0, dout_valid}, 32'd0);
    drain();

    // Reset mid-word, then 8'h5A into the detector model
    send_word(8'h3C, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_dout", {31'd0, dout}, 32'd0);
    check("t6_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    send_word(8'h5A, 1, 1'b0);
    drain();
    check("t6_det_pulses", det_pulses, 32'd1);
    check("t6_det_bit", det_last, 32'd8);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
